// File: rtl/jk_pkg.sv
// Shared JK operation encodings and the modulo next-count helper for the
// JK-cell based up/down counter.
package jk_pkg;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  // Out-of-range counts recover to 0 on the next count edge in either direction.
  function automatic int unsigned next_count(input int unsigned cur,
                                             input logic        up,
                                             input int unsigned modulus);
    if (cur >= modulus) return 0;
    if (up) return (cur == modulus - 1) ? 0 : cur + 1;
    return (cur == 0) ? modulus - 1 : cur - 1;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with asynchronous active-low reset to 0.
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic res,
  input  logic j,
  input  logic k,
  output logic q
);

  logic r_q;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_q <= 1'b0;
    end else begin
      case ({j, k})
        JK_HOLD: r_q <= r_q;
        JK_RST:  r_q <= 1'b0;
        JK_SET:  r_q <= 1'b1;
        default: r_q <= ~r_q;
      endcase
    end
  end

  assign q = r_q;

endmodule

// File: rtl/jk_updown_counter.sv
// Mod-MODULUS up/down counter built from JK cells, with parallel load,
// combinational terminal count and a sticky wrap flag.
module jk_updown_counter
  import jk_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_wrap,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrapped
);

  localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_nxt;
  logic [WIDTH-1:0] w_din_c;
  logic [1:0]       w_op [WIDTH];
  logic             w_tc;
  logic             r_wrapped;

  assign w_din_c = (32'(din) >= MODULUS) ? LP_MAX : din;
  assign w_nxt   = WIDTH'(next_count(32'(w_q), up, MODULUS));
  assign w_tc    = en & ((up & (w_q == LP_MAX)) | (~up & (w_q == '0)));

  // Load forces each cell via set/reset; counting toggles only the bits that change.
  always_comb begin
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_op[i] = JK_HOLD;
      if (load) begin
        w_op[i] = w_din_c[i] ? JK_SET : JK_RST;
      end else if (en) begin
        w_op[i] = (w_nxt[i] != w_q[i]) ? JK_TGL : JK_HOLD;
      end
    end
  end

  for (genvar g = 0; g < int'(WIDTH); g++) begin : g_cell
    jk_cell u_cell (
      .clk (clk),
      .res (res),
      .j   (w_op[g][1]),
      .k   (w_op[g][0]),
      .q   (w_q[g])
    );
  end

  // A wrap on the same edge as clr_wrap keeps the flag set.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_wrapped <= 1'b0;
    end else if (w_tc && !load) begin
      r_wrapped <= 1'b1;
    end else if (clr_wrap) begin
      r_wrapped <= 1'b0;
    end
  end

  assign q       = w_q;
  assign tc      = w_tc;
  assign wrapped = r_wrapped;

endmodule

// File: tb/tb_jk_updown_counter.sv
// Bench for jk_updown_counter: directed scenarios plus random stimulus against
// a modulo-arithmetic reference model.
module tb_jk_updown_counter;

  localparam int W = 4;
  localparam int M = 10;

  logic         clk;
  logic         res;
  logic         en;
  logic         up;
  logic         load;
  logic [W-1:0] din;
  logic         clr_wrap;
  logic [W-1:0] q;
  logic         tc;
  logic         wrapped;

  int n_checks = 0;
  int n_errors = 0;
  int m_q      = 0;
  int m_w      = 0;
  int m_tc     = 0;

  jk_updown_counter #(.WIDTH(W), .MODULUS(M)) u_dut (
    .clk      (clk),
    .res      (res),
    .en       (en),
    .up       (up),
    .load     (load),
    .din      (din),
    .clr_wrap (clr_wrap),
    .q        (q),
    .tc       (tc),
    .wrapped  (wrapped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called just after a falling edge: drive, check tc, clock once, check state.
  task automatic cyc(input logic l, input logic e, input logic u,
                     input logic c, input logic [W-1:0] d);
    load = l; en = e; up = u; clr_wrap = c; din = d;
    #1;
    m_tc = (e && ((u && m_q == M - 1) || (!u && m_q == 0))) ? 1 : 0;
    check("tc", 32'(tc), 32'(m_tc));
    @(posedge clk);
    if (l) m_q = (int'(d) >= M) ? M - 1 : int'(d);
    else if (e) m_q = u ? (m_q + 1) % M : (m_q + M - 1) % M;
    if (m_tc == 1 && !l) m_w = 1;
    else if (c) m_w = 0;
    @(negedge clk);
    check("q", 32'(q), 32'(m_q));
    check("wrapped", 32'(wrapped), 32'(m_w));
  endtask

  initial begin
    res = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; din = '0; clr_wrap = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_q", 32'(q), 32'd0);
    check("rst_wrapped", 32'(wrapped), 32'd0);
    check("rst_tc_en0", 32'(tc), 32'd0);
    res = 1'b1;
    @(negedge clk);

    // Count up from 0 through the wrap to 2.
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, '0);
    check("up_end_q", 32'(q), 32'd2);
    check("up_wrapped", 32'(wrapped), 32'd1);

    // Continue to 7, then assert reset mid-cycle.
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, '0);
    check("pre_rst_q", 32'(q), 32'd7);
    en = 1'b0;
    #2 res = 1'b0;
    #1;
    check("async_q", 32'(q), 32'd0);
    check("async_wrapped", 32'(wrapped), 32'd0);
    m_q = 0; m_w = 0;
    @(negedge clk);
    res = 1'b1;

    // Count down from 0: 9, 8, 7.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    check("down_q", 32'(q), 32'd7);

    // Load clamp and load-over-enable priority.
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'd13);
    check("load_clamp", 32'(q), 32'd9);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd3);
    check("load_wins", 32'(q), 32'd3);

    // Wrap and clear on the same edge: set wins; then clear alone.
    cyc(1'b0, 1'b0, 1'b1, 1'b1, '0);
    check("wrap_cleared", 32'(wrapped), 32'd0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'd9);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, '0);
    check("set_wins", 32'(wrapped), 32'd1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, '0);
    check("clr_after", 32'(wrapped), 32'd0);

    // Disabled counter with toggling direction holds.
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'd5);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'(i % 2), 1'b0, '0);
    check("hold_q", 32'(q), 32'd5);

    // Random stimulus.
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
          W'($urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
